sprite_pixel_fetch: RTL and testbench

- Per-pixel sprite source that drives the colour mapper's sprite inputs: the hit flag (sprite_on) and the 24-bit pixel word (pixel_out).
- Takes the VGA scan coordinates and a sprite position, generates addresses into a synchronous sprite ROM, applies horizontal flip and frame-based animation, and masks the key colour as transparent.
- One instance per sprite, e.g. the mario and gomba instances.

---
 rtl/sprite_pixel_fetch_if.sv | 33 +++
 rtl/sprite_pixel_fetch.sv | 115 +++++++++++
 tb/tb_sprite_pixel_fetch.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_pixel_fetch_if.sv
// Scan, control and sprite-ROM signals between the VGA pipeline (master) and one sprite fetch unit (slave).
interface sprite_pixel_fetch_if #(
    parameter int ADDR_W = 12
);
    logic              frame_start;
    logic [9:0]        pos_x_in;
    logic [9:0]        pos_y_in;
    logic              flip_in;
    logic              visible_in;
    logic              anim_en;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              pixel_valid;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rd;
    logic [23:0]       rom_data;
    logic              sprite_on;
    logic [23:0]       pixel_out;

    // rom_rd qualifies rom_addr for one cycle; the ROM answers on rom_data one cycle later.
    // There is no backpressure anywhere: one pixel enters and one leaves every cycle.
    modport master (
        output frame_start, pos_x_in, pos_y_in, flip_in, visible_in, anim_en,
        output DrawX, DrawY, pixel_valid, rom_data,
        input  rom_addr, rom_rd, sprite_on, pixel_out
    );

    modport slave (
        input  frame_start, pos_x_in, pos_y_in, flip_in, visible_in, anim_en,
        input  DrawX, DrawY, pixel_valid, rom_data,
        output rom_addr, rom_rd, sprite_on, pixel_out
    );
endinterface

// File: rtl/sprite_pixel_fetch.sv
// Per-sprite pixel source: hit test on the scan position, sync-ROM fetch with flip and animation,
// key-colour transparency. Output lags DrawX/DrawY by exactly 3 cycles.
module sprite_pixel_fetch #(
    parameter int          SPR_W       = 32,
    parameter int          SPR_H       = 32,
    parameter int          ANIM_FRAMES = 4,
    parameter int          ANIM_DIV    = 8,
    parameter int          ADDR_W      = 12,
    parameter logic [23:0] KEY_COLOR   = 24'hFF00FF
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    sprite_pixel_fetch_if.slave  bus,
    output logic                 state_dbg
);
    localparam int COL_W = $clog2(SPR_W);
    localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int IDX_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    typedef enum logic {WAIT_FRAME = 1'b0, ACTIVE = 1'b1} state_t;

    state_t             state, state_next;
    logic               latch_en;
    logic [9:0]         pos_x_l, pos_y_l;
    logic               flip_l, visible_l;
    logic [IDX_W-1:0]   anim_idx;
    logic [DIV_W-1:0]   div_cnt;
    logic [10:0]        x_end, y_end;
    logic [COL_W-1:0]   col_raw, col;
    logic [ROW_W-1:0]   row;
    logic [ADDR_W-1:0]  addr0;
    logic               hit0, hit1, hit2, opaque;

    assign state_dbg = (state == ACTIVE);

    always_ff @(posedge Clk) begin
        if (!Reset_n) state <= WAIT_FRAME;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        latch_en   = 1'b0;
        case (state)
            WAIT_FRAME: begin
                if (bus.frame_start) begin
                    latch_en   = 1'b1;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: latch_en = bus.frame_start;
        endcase
    end

    // Position is only ever taken at frame_start so it cannot tear mid-frame.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            pos_x_l   <= '0;
            pos_y_l   <= '0;
            flip_l    <= 1'b0;
            visible_l <= 1'b0;
        end else if (latch_en) begin
            pos_x_l   <= bus.pos_x_in;
            pos_y_l   <= bus.pos_y_in;
            flip_l    <= bus.flip_in;
            visible_l <= bus.visible_in;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            div_cnt  <= '0;
            anim_idx <= '0;
        end else if (bus.frame_start && bus.anim_en) begin
            if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
                div_cnt  <= '0;
                anim_idx <= (anim_idx == IDX_W'(ANIM_FRAMES - 1)) ? '0 : anim_idx + IDX_W'(1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // 11-bit right/bottom edges so a sprite near the screen edge clips instead of wrapping.
    assign x_end   = {1'b0, pos_x_l} + 11'(SPR_W);
    assign y_end   = {1'b0, pos_y_l} + 11'(SPR_H);
    assign hit0    = (state == ACTIVE) && visible_l && bus.pixel_valid
                   && (bus.DrawX >= pos_x_l) && ({1'b0, bus.DrawX} < x_end)
                   && (bus.DrawY >= pos_y_l) && ({1'b0, bus.DrawY} < y_end);
    assign col_raw = COL_W'(bus.DrawX - pos_x_l);
    assign col     = flip_l ? (COL_W'(SPR_W - 1) - col_raw) : col_raw;
    assign row     = ROW_W'(bus.DrawY - pos_y_l);
    assign addr0   = ADDR_W'(anim_idx) * ADDR_W'(SPR_W * SPR_H)
                   + ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col);

    assign opaque     = hit2 && (bus.rom_data != KEY_COLOR);
    assign bus.rom_rd = hit1;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            bus.rom_addr  <= '0;
            hit1          <= 1'b0;
            hit2          <= 1'b0;
            bus.sprite_on <= 1'b0;
            bus.pixel_out <= '0;
        end else begin
            if (hit0) bus.rom_addr <= addr0;
            hit1          <= hit0;
            hit2          <= hit1;
            bus.sprite_on <= opaque;
            bus.pixel_out <= opaque ? bus.rom_data : 24'h0;
        end
    end
endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Directed bench for sprite_pixel_fetch: hit window, flip, key colour, animation stepping,
// screen-edge clipping and mid-pipeline reset, against a synchronous ROM model.
module tb_sprite_pixel_fetch;
    localparam logic [23:0] KEY = 24'hFF00FF;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic state_dbg;
    logic key_mode = 1'b0;
    logic [23:0] rom_q = 24'h0;
    int n_cmp = 0;
    int n_err = 0;

    int m_active, m_px, m_py, m_flip, m_vis, m_anim, m_div;

    always #5 Clk = ~Clk;

    sprite_pixel_fetch_if #(.ADDR_W(12)) bus ();

    sprite_pixel_fetch #(
        .SPR_W(32), .SPR_H(32), .ANIM_FRAMES(4), .ANIM_DIV(8), .ADDR_W(12), .KEY_COLOR(KEY)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    function automatic logic [23:0] rom_word(input logic [11:0] a, input logic km);
        if (km) return KEY;
        if (a == 12'd0) return 24'h00FF00;
        return {12'hA00, a};
    endfunction

    always @(posedge Clk) rom_q <= rom_word(bus.rom_addr, key_mode);
    assign bus.rom_data = rom_q;

    function automatic bit exp_hit(input int x, input int y);
        return (m_active != 0) && (m_vis != 0) && x >= m_px && x < m_px + 32 && y >= m_py && y < m_py + 32;
    endfunction

    function automatic int exp_addr(input int x, input int y);
        int col;
        col = x - m_px;
        if (m_flip != 0) col = 31 - col;
        return (m_anim * 1024 + (y - m_py) * 32 + col) % 4096;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        bus.frame_start = 1'b0;
        bus.pixel_valid = 1'b0;
        cycles(2);
        Reset_n = 1'b1;
        m_active = 0; m_px = 0; m_py = 0; m_flip = 0; m_vis = 0; m_anim = 0; m_div = 0;
    endtask

    task automatic pulse_frame();
        bus.frame_start = 1'b1;
        cycles(1);
        bus.frame_start = 1'b0;
        m_active = 1;
        m_px = bus.pos_x_in; m_py = bus.pos_y_in; m_flip = bus.flip_in; m_vis = bus.visible_in;
        if (bus.anim_en) begin
            if (m_div == 7) begin
                m_div = 0;
                m_anim = (m_anim == 3) ? 0 : m_anim + 1;
            end else begin
                m_div = m_div + 1;
            end
        end
    endtask

    task automatic set_pos(input int x, input int y, input logic flip, input logic vis);
        bus.pos_x_in = 10'(x); bus.pos_y_in = 10'(y); bus.flip_in = flip; bus.visible_in = vis;
    endtask

    // Drives one pixel, then blanks; returns one cycle after the pixel entered (rom_addr stage).
    task automatic drive_pixel(input int x, input int y, input logic valid);
        bus.DrawX = 10'(x); bus.DrawY = 10'(y); bus.pixel_valid = valid;
        cycles(1);
        bus.pixel_valid = 1'b0;
    endtask

    // Streams a run of pixels at one per cycle and checks every pixel at its stage-1 and output slots.
    task automatic scan_row(input string name, input int y, input int x0, input int x1);
        logic [24:0] exp_q[$];
        logic [24:0] e;
        logic [23:0] w;
        bit h;
        int n;
        n = x1 - x0 + 1;
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                bus.DrawX = 10'(x0 + i); bus.DrawY = 10'(y); bus.pixel_valid = 1'b1;
                h = exp_hit(x0 + i, y);
                w = rom_word(12'(exp_addr(x0 + i, y)), key_mode);
                exp_q.push_back((h && w != KEY) ? {1'b1, w} : 25'h0);
            end else begin
                bus.pixel_valid = 1'b0;
                h = 1'b0;
            end
            cycles(1);
            n_cmp++;
            if (bus.rom_rd !== h) begin
                n_err++;
                $display("FAIL %s_rd y=%0d i=%0d: got %b want %b", name, y, i, bus.rom_rd, h);
            end
            if (i >= 2) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({bus.sprite_on, bus.pixel_out} !== e) begin
                    n_err++;
                    $display("FAIL %s_out y=%0d x=%0d: got %b/%h want %b/%h", name, y, x0 + i - 2,
                             bus.sprite_on, bus.pixel_out, e[24], e[23:0]);
                end
            end
        end
    endtask

    task automatic test_reset();
        cycles(3);
        n_cmp++;
        if ({bus.sprite_on, bus.rom_rd, state_dbg} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got on=%b rd=%b st=%b want 0/0/0", bus.sprite_on, bus.rom_rd, state_dbg);
        end
        n_cmp++;
        if ({bus.pixel_out, bus.rom_addr} !== 36'h0) begin
            n_err++;
            $display("FAIL reset_data: got pix=%h addr=%h want 0/0", bus.pixel_out, bus.rom_addr);
        end
        Reset_n = 1'b1;
        set_pos(100, 50, 1'b0, 1'b1);
        scan_row("no_frame", 50, 96, 135);
        scan_row("no_frame", 81, 96, 135);
    endtask

    task automatic test_basic_hit();
        set_pos(100, 50, 1'b0, 1'b1);
        pulse_frame();
        drive_pixel(100, 50, 1'b1);
        n_cmp++;
        if ({bus.rom_rd, bus.rom_addr} !== {1'b1, 12'd0}) begin
            n_err++;
            $display("FAIL basic_addr: got rd=%b addr=%0d want 1/0", bus.rom_rd, bus.rom_addr);
        end
        cycles(2);
        n_cmp++;
        if ({bus.sprite_on, bus.pixel_out} !== {1'b1, 24'h00FF00}) begin
            n_err++;
            $display("FAIL basic_pix: got %b/%h want 1/00ff00", bus.sprite_on, bus.pixel_out);
        end
        drive_pixel(131, 81, 1'b1);
        cycles(2);
        n_cmp++;
        if ({bus.sprite_on, bus.pixel_out} !== {1'b1, 24'hA003FF}) begin
            n_err++;
            $display("FAIL basic_corner: got %b/%h want 1/a003ff", bus.sprite_on, bus.pixel_out);
        end
        drive_pixel(99, 50, 1'b1);
        cycles(2);
        n_cmp++;
        if (bus.sprite_on !== 1'b0) begin
            n_err++;
            $display("FAIL basic_left: got %b want 0", bus.sprite_on);
        end
        drive_pixel(132, 50, 1'b1);
        cycles(2);
        n_cmp++;
        if (bus.sprite_on !== 1'b0) begin
            n_err++;
            $display("FAIL basic_right: got %b want 0", bus.sprite_on);
        end
        drive_pixel(100, 82, 1'b1);
        cycles(2);
        n_cmp++;
        if (bus.sprite_on !== 1'b0) begin
            n_err++;
            $display("FAIL basic_below: got %b want 0", bus.sprite_on);
        end
        drive_pixel(100, 50, 1'b0);
        n_cmp++;
        if (bus.rom_rd !== 1'b0) begin
            n_err++;
            $display("FAIL basic_blank: got rd=%b want 0", bus.rom_rd);
        end
        cycles(2);
    endtask

    task automatic test_flip();
        set_pos(100, 50, 1'b1, 1'b1);
        pulse_frame();
        drive_pixel(100, 51, 1'b1);
        n_cmp++;
        if (bus.rom_addr !== 12'd63) begin
            n_err++;
            $display("FAIL flip_addr: got %0d want 63", bus.rom_addr);
        end
        cycles(2);
        n_cmp++;
        if ({bus.sprite_on, bus.pixel_out} !== {1'b1, 24'hA0003F}) begin
            n_err++;
            $display("FAIL flip_pix: got %b/%h want 1/a0003f", bus.sprite_on, bus.pixel_out);
        end
        drive_pixel(131, 50, 1'b1);
        n_cmp++;
        if (bus.rom_addr !== 12'd0) begin
            n_err++;
            $display("FAIL flip_right_addr: got %0d want 0", bus.rom_addr);
        end
        cycles(2);
    endtask

    task automatic test_key();
        set_pos(100, 50, 1'b0, 1'b1);
        pulse_frame();
        key_mode = 1'b1;
        drive_pixel(110, 60, 1'b1);
        n_cmp++;
        if (bus.rom_rd !== 1'b1) begin
            n_err++;
            $display("FAIL key_rd: got %b want 1", bus.rom_rd);
        end
        cycles(2);
        n_cmp++;
        if ({bus.sprite_on, bus.pixel_out} !== 25'h0) begin
            n_err++;
            $display("FAIL key_pix: got %b/%h want 0/000000", bus.sprite_on, bus.pixel_out);
        end
        key_mode = 1'b0;
    endtask

    task automatic test_latch_hold();
        set_pos(100, 50, 1'b0, 1'b1);
        pulse_frame();
        set_pos(200, 50, 1'b0, 1'b0);
        drive_pixel(100, 50, 1'b1);
        cycles(2);
        n_cmp++;
        if (bus.sprite_on !== 1'b1) begin
            n_err++;
            $display("FAIL hold_old_pos: got %b want 1", bus.sprite_on);
        end
        drive_pixel(200, 50, 1'b1);
        n_cmp++;
        if (bus.rom_rd !== 1'b0) begin
            n_err++;
            $display("FAIL hold_new_pos: got rd=%b want 0", bus.rom_rd);
        end
        cycles(2);
        pulse_frame();
        drive_pixel(200, 50, 1'b1);
        n_cmp++;
        if (bus.rom_rd !== 1'b0) begin
            n_err++;
            $display("FAIL invisible: got rd=%b want 0", bus.rom_rd);
        end
        cycles(2);
    endtask

    task automatic test_anim();
        do_reset();
        set_pos(100, 50, 1'b0, 1'b1);
        bus.anim_en = 1'b1;
        for (int i = 0; i < 7; i++) pulse_frame();
        drive_pixel(100, 50, 1'b1);
        n_cmp++;
        if ({bus.rom_rd, bus.rom_addr} !== {1'b1, 12'd0}) begin
            n_err++;
            $display("FAIL anim_7: got rd=%b addr=%0d want 1/0", bus.rom_rd, bus.rom_addr);
        end
        cycles(2);
        pulse_frame();
        drive_pixel(100, 50, 1'b1);
        n_cmp++;
        if (bus.rom_addr !== 12'd1024) begin
            n_err++;
            $display("FAIL anim_8: got %0d want 1024", bus.rom_addr);
        end
        cycles(2);
        n_cmp++;
        if (bus.pixel_out !== 24'hA00400) begin
            n_err++;
            $display("FAIL anim_8_pix: got %h want a00400", bus.pixel_out);
        end
        for (int i = 0; i < 24; i++) pulse_frame();
        drive_pixel(100, 50, 1'b1);
        n_cmp++;
        if (bus.rom_addr !== 12'd0) begin
            n_err++;
            $display("FAIL anim_32_wrap: got %0d want 0", bus.rom_addr);
        end
        cycles(2);
        bus.anim_en = 1'b0;
        pulse_frame();
        drive_pixel(101, 50, 1'b1);
        n_cmp++;
        if (bus.rom_addr !== 12'd1) begin
            n_err++;
            $display("FAIL anim_hold: got %0d want 1", bus.rom_addr);
        end
        cycles(2);
    endtask

    task automatic test_screen_edge();
        set_pos(620, 470, 1'b0, 1'b1);
        pulse_frame();
        scan_row("edge", 469, 615, 639);
        scan_row("edge", 470, 615, 639);
        scan_row("edge", 479, 600, 639);
        scan_row("edge_wrap", 479, 0, 11);
        scan_row("edge_wrap", 470, 0, 11);
    endtask

    task automatic test_reset_midflight();
        drive_pixel(625, 475, 1'b1);
        n_cmp++;
        if (bus.rom_rd !== 1'b1) begin
            n_err++;
            $display("FAIL mid_inflight: got rd=%b want 1", bus.rom_rd);
        end
        Reset_n = 1'b0;
        cycles(1);
        Reset_n = 1'b1;
        m_active = 0; m_vis = 0; m_anim = 0; m_div = 0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({bus.sprite_on, bus.pixel_out, state_dbg} !== 26'h0) begin
                n_err++;
                $display("FAIL mid_flush c=%0d: got on=%b pix=%h st=%b want 0/0/0", i,
                         bus.sprite_on, bus.pixel_out, state_dbg);
            end
            cycles(1);
        end
        drive_pixel(625, 475, 1'b1);
        n_cmp++;
        if (bus.rom_rd !== 1'b0) begin
            n_err++;
            $display("FAIL mid_wait_frame: got rd=%b want 0", bus.rom_rd);
        end
        cycles(3);
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.anim_en     = 1'b0;
        bus.pixel_valid = 1'b0;
        bus.DrawX       = '0;
        bus.DrawY       = '0;
        set_pos(0, 0, 1'b0, 1'b0);
        m_active = 0; m_px = 0; m_py = 0; m_flip = 0; m_vis = 0; m_anim = 0; m_div = 0;
        test_reset();
        test_basic_hit();
        test_flip();
        test_key();
        test_latch_hold();
        test_anim();
        test_screen_edge();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
